// File: rtl/async_queue_sink_3.sv
// ============================================================================
// async_queue_sink_3
// Receive (dequeue) end of a single-entry asynchronous queue used for the
// debug-control clock crossing. Synchronizes the source's Gray write index and
// safe-reset handshake into `clock`, presents a ready/valid dequeue port and
// returns the read index plus sink-alive status to the source.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

// 3-stage asynchronous-reset synchronizer, resets to 0. Used both as the
// AsyncValidSync stages and as the write-index synchronizer.
module async_queue_sink_3_sync3 (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [2:0] sync_q;

  // Shift the foreign-domain bit through three flops; clear asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], d_i};
    end
  end

  assign q_o = sync_q[2];

endmodule

module async_queue_sink_3 (
  input  logic       clock,
  input  logic       reset,
  input  logic       io_deq_ready,
  output logic       io_deq_valid,
  output logic       io_deq_bits_resumereq,
  output logic [9:0] io_deq_bits_hartsel,
  output logic       io_deq_bits_ackhavereset,
  output logic       io_deq_bits_hasel,
  output logic       io_deq_bits_hamask_0,
  output logic       io_deq_bits_hrmask_0,
  input  logic       io_async_mem_0_resumereq,
  input  logic [9:0] io_async_mem_0_hartsel,
  input  logic       io_async_mem_0_ackhavereset,
  input  logic       io_async_mem_0_hasel,
  input  logic       io_async_mem_0_hamask_0,
  input  logic       io_async_mem_0_hrmask_0,
  input  logic       io_async_widx,
  output logic       io_async_ridx,
  input  logic       io_async_safe_widx_valid,
  input  logic       io_async_safe_source_reset_n,
  output logic       io_async_safe_ridx_valid,
  output logic       io_async_safe_sink_reset_n
);

  // Reset for everything that must die with the source.
  logic source_rst;
  // Local reset: held while the source is not known to be alive.
  logic lrst;

  logic sink_extend_out;
  logic sink_ready;
  logic source_valid_0_out;
  logic widx_s;

  logic fire;
  logic ridx_nxt;
  logic valid;

  logic        ridx_bin_q;
  logic        ridx_bin_d;
  logic        valid_reg_q;
  logic        ridx_reg_q;
  logic [14:0] deq_bits_q;
  logic [14:0] deq_bits_d;

  assign source_rst = reset | ~io_async_safe_source_reset_n;
  assign lrst       = reset | ~sink_ready;

  // Source-alive detection: extend stage dies with the source, valid stage
  // only with the local reset.
  async_queue_sink_3_sync3 u_sink_extend (
    .clock (clock),
    .reset (source_rst),
    .d_i   (io_async_safe_widx_valid),
    .q_o   (sink_extend_out)
  );

  async_queue_sink_3_sync3 u_sink_valid (
    .clock (clock),
    .reset (reset),
    .d_i   (sink_extend_out),
    .q_o   (sink_ready)
  );

  // Sink-alive indication travelling back to the source.
  async_queue_sink_3_sync3 u_source_valid_0 (
    .clock (clock),
    .reset (source_rst),
    .d_i   (1'b1),
    .q_o   (source_valid_0_out)
  );

  async_queue_sink_3_sync3 u_source_valid_1 (
    .clock (clock),
    .reset (source_rst),
    .d_i   (source_valid_0_out),
    .q_o   (io_async_safe_ridx_valid)
  );

  // Write index brought into the sink domain.
  async_queue_sink_3_sync3 u_widx_sync (
    .clock (clock),
    .reset (lrst),
    .d_i   (io_async_widx),
    .q_o   (widx_s)
  );

  assign fire       = io_deq_valid & io_deq_ready;
  // With a depth of one, the 1-bit binary index is also its Gray code.
  assign ridx_nxt   = sink_ready ? (ridx_bin_q ^ fire) : 1'b0;
  assign ridx_bin_d = ridx_nxt;
  // Using the post-consume index keeps a just-fired entry from reappearing.
  assign valid      = sink_ready & (ridx_nxt != widx_s);

  assign deq_bits_d = {io_async_mem_0_resumereq, io_async_mem_0_hartsel,
                       io_async_mem_0_ackhavereset, io_async_mem_0_hasel,
                       io_async_mem_0_hamask_0, io_async_mem_0_hrmask_0};

  // Read pointer and registered handshake state, cleared while source is down.
  always_ff @(posedge clock or posedge lrst) begin
    if (lrst) begin
      ridx_bin_q  <= 1'b0;
      valid_reg_q <= 1'b0;
      ridx_reg_q  <= 1'b0;
    end else begin
      ridx_bin_q  <= ridx_bin_d;
      valid_reg_q <= valid;
      ridx_reg_q  <= ridx_nxt;
    end
  end

  // Payload capture: the slot is only sampled while it is known to be stable.
  always_ff @(posedge clock) begin
    if (valid) begin
      deq_bits_q <= deq_bits_d;
    end
  end

  assign io_deq_valid  = valid_reg_q & sink_ready;
  assign io_async_ridx = ridx_reg_q;

  assign io_deq_bits_resumereq    = deq_bits_q[14];
  assign io_deq_bits_hartsel      = deq_bits_q[13:4];
  assign io_deq_bits_ackhavereset = deq_bits_q[3];
  assign io_deq_bits_hasel        = deq_bits_q[2];
  assign io_deq_bits_hamask_0     = deq_bits_q[1];
  assign io_deq_bits_hrmask_0     = deq_bits_q[0];

  assign io_async_safe_sink_reset_n = ~reset;

endmodule

`default_nettype wire

// File: tb/tb_async_queue_sink_3.sv
// ============================================================================
// tb_async_queue_sink_3
// Self-checking bench for async_queue_sink_3. The bench plays the source end:
// it owns the payload slot and write index, and tracks the in-order stream of
// sent entries that the sink must deliver exactly once.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_async_queue_sink_3;

  logic       clock;
  logic       reset;
  logic       io_deq_ready;
  logic       io_deq_valid;
  logic       io_deq_bits_resumereq;
  logic [9:0] io_deq_bits_hartsel;
  logic       io_deq_bits_ackhavereset;
  logic       io_deq_bits_hasel;
  logic       io_deq_bits_hamask_0;
  logic       io_deq_bits_hrmask_0;
  logic       io_async_mem_0_resumereq;
  logic [9:0] io_async_mem_0_hartsel;
  logic       io_async_mem_0_ackhavereset;
  logic       io_async_mem_0_hasel;
  logic       io_async_mem_0_hamask_0;
  logic       io_async_mem_0_hrmask_0;
  logic       io_async_widx;
  logic       io_async_ridx;
  logic       io_async_safe_widx_valid;
  logic       io_async_safe_source_reset_n;
  logic       io_async_safe_ridx_valid;
  logic       io_async_safe_sink_reset_n;

  async_queue_sink_3 dut (
    .clock                        (clock),
    .reset                        (reset),
    .io_deq_ready                 (io_deq_ready),
    .io_deq_valid                 (io_deq_valid),
    .io_deq_bits_resumereq        (io_deq_bits_resumereq),
    .io_deq_bits_hartsel          (io_deq_bits_hartsel),
    .io_deq_bits_ackhavereset     (io_deq_bits_ackhavereset),
    .io_deq_bits_hasel            (io_deq_bits_hasel),
    .io_deq_bits_hamask_0         (io_deq_bits_hamask_0),
    .io_deq_bits_hrmask_0         (io_deq_bits_hrmask_0),
    .io_async_mem_0_resumereq     (io_async_mem_0_resumereq),
    .io_async_mem_0_hartsel       (io_async_mem_0_hartsel),
    .io_async_mem_0_ackhavereset  (io_async_mem_0_ackhavereset),
    .io_async_mem_0_hasel         (io_async_mem_0_hasel),
    .io_async_mem_0_hamask_0      (io_async_mem_0_hamask_0),
    .io_async_mem_0_hrmask_0      (io_async_mem_0_hrmask_0),
    .io_async_widx                (io_async_widx),
    .io_async_ridx                (io_async_ridx),
    .io_async_safe_widx_valid     (io_async_safe_widx_valid),
    .io_async_safe_source_reset_n (io_async_safe_source_reset_n),
    .io_async_safe_ridx_valid     (io_async_safe_ridx_valid),
    .io_async_safe_sink_reset_n   (io_async_safe_sink_reset_n)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Expected read index: the number of entries consumed since the last
  // reset of the link, modulo two.
  logic exp_ridx;

  typedef struct {
    logic [14:0] payload;
    int          hold;
    logic        ridx_after;
  } vec_t;

  vec_t vecs[4];

  logic [14:0] expq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [14:0] deq_bits();
    return {io_deq_bits_resumereq, io_deq_bits_hartsel, io_deq_bits_ackhavereset,
            io_deq_bits_hasel, io_deq_bits_hamask_0, io_deq_bits_hrmask_0};
  endfunction

  // Source side: write the slot, then advance the write index.
  task automatic send(input logic [14:0] p);
    {io_async_mem_0_resumereq, io_async_mem_0_hartsel, io_async_mem_0_ackhavereset,
     io_async_mem_0_hasel, io_async_mem_0_hamask_0, io_async_mem_0_hrmask_0} = p;
    io_async_widx = ~io_async_widx;
  endtask

  // Enqueue with consumer stalled: entry must appear exactly four edges later.
  task automatic transfer_exact(input string name, input logic [14:0] p, input int hold);
    io_deq_ready = 1'b0;
    send(p);
    repeat (3) tick();
    chk({name, " valid_before_latency"}, {31'd0, io_deq_valid}, 32'd0);
    tick();
    chk({name, " valid_at_latency"}, {31'd0, io_deq_valid}, 32'd1);
    chk({name, " bits"}, {17'd0, deq_bits()}, {17'd0, p});
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({name, " hold_valid"}, {31'd0, io_deq_valid}, 32'd1);
      chk({name, " hold_bits"}, {17'd0, deq_bits()}, {17'd0, p});
    end
    io_deq_ready = 1'b1;
    tick();
    io_deq_ready = 1'b0;
    exp_ridx = ~exp_ridx;
    chk({name, " valid_after_fire"}, {31'd0, io_deq_valid}, 32'd0);
    chk({name, " ridx_after_fire"}, {31'd0, io_async_ridx}, {31'd0, exp_ridx});
  endtask

  task automatic bring_up(input string name);
    repeat (5) tick();
    chk({name, " ridx_valid_early"}, {31'd0, io_async_safe_ridx_valid}, 32'd0);
    tick();
    chk({name, " ridx_valid_on_time"}, {31'd0, io_async_safe_ridx_valid}, 32'd1);
    repeat (2) tick();
  endtask

  initial begin
    int sends;
    int fires;
    int cyc;
    logic [14:0] p;
    logic [14:0] head;

    vecs[0] = '{payload: 15'h4001, hold: 3, ridx_after: 1'b1};
    vecs[1] = '{payload: 15'h3FFE, hold: 0, ridx_after: 1'b0};
    vecs[2] = '{payload: 15'h2AA5, hold: 7, ridx_after: 1'b1};
    vecs[3] = '{payload: 15'h1554, hold: 1, ridx_after: 1'b0};

    reset = 1'b1;
    io_deq_ready = 1'b0;
    io_async_widx = 1'b0;
    io_async_safe_widx_valid = 1'b1;
    io_async_safe_source_reset_n = 1'b1;
    {io_async_mem_0_resumereq, io_async_mem_0_hartsel, io_async_mem_0_ackhavereset,
     io_async_mem_0_hasel, io_async_mem_0_hamask_0, io_async_mem_0_hrmask_0} = 15'h0;
    exp_ridx = 1'b0;

    // Reset state.
    repeat (3) tick();
    chk("rst deq_valid", {31'd0, io_deq_valid}, 32'd0);
    chk("rst ridx", {31'd0, io_async_ridx}, 32'd0);
    chk("rst ridx_valid", {31'd0, io_async_safe_ridx_valid}, 32'd0);
    chk("rst sink_reset_n", {31'd0, io_async_safe_sink_reset_n}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rel sink_reset_n", {31'd0, io_async_safe_sink_reset_n}, 32'd1);
    bring_up("bringup");

    // Table-driven transfers: single transfer, then wrap 1,0,1,0.
    for (int i = 0; i < 4; i++) begin
      transfer_exact($sformatf("vec%0d", i), vecs[i].payload, vecs[i].hold);
      chk($sformatf("vec%0d ridx_table", i), {31'd0, io_async_ridx}, {31'd0, vecs[i].ridx_after});
    end

    // Empty queue with consumer ready: nothing may fire.
    io_deq_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("empty no_valid", {31'd0, io_deq_valid}, 32'd0);
      chk("empty ridx_const", {31'd0, io_async_ridx}, {31'd0, exp_ridx});
    end
    io_deq_ready = 1'b0;

    // Randomized traffic against an in-order, exactly-once stream model.
    sends = 0;
    fires = 0;
    cyc = 0;
    while (fires < 24 && cyc < 4000) begin
      io_deq_ready = ($urandom_range(0, 3) != 0);
      if (io_deq_valid && io_deq_ready) begin
        fires++;
        exp_ridx = ~exp_ridx;
        if (expq.size() == 0) begin
          chk("rand spurious_fire", 32'd1, 32'd0);
        end else begin
          head = expq.pop_front();
          chk("rand fire_bits", {17'd0, deq_bits()}, {17'd0, head});
        end
      end
      if (sends < 24 && io_async_ridx == io_async_widx && $urandom_range(0, 1) == 1) begin
        p = 15'($urandom);
        send(p);
        expq.push_back(p);
        sends++;
      end
      tick();
      cyc++;
    end
    chk("rand fire_count", fires, 32'd24);
    chk("rand queue_drained", expq.size(), 32'd0);
    io_deq_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rand no_duplicate", {31'd0, io_deq_valid}, 32'd0);
    end
    io_deq_ready = 1'b0;
    chk("rand ridx_parity", {31'd0, io_async_ridx}, {31'd0, exp_ridx});

    // Source reset with an entry pending.
    send(15'h0ABC);
    repeat (5) tick();
    chk("srcrst pending_valid", {31'd0, io_deq_valid}, 32'd1);
    io_async_safe_source_reset_n = 1'b0;
    io_async_safe_widx_valid = 1'b0;
    io_async_widx = 1'b0;
    exp_ridx = 1'b0;
    #1;
    chk("srcrst ridx_valid_drop", {31'd0, io_async_safe_ridx_valid}, 32'd0);
    repeat (6) tick();
    chk("srcrst deq_valid", {31'd0, io_deq_valid}, 32'd0);
    chk("srcrst ridx", {31'd0, io_async_ridx}, 32'd0);
    io_async_safe_source_reset_n = 1'b1;
    io_async_safe_widx_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("srcrst no_spurious", {31'd0, io_deq_valid}, 32'd0);
    end
    chk("srcrst ridx_valid_back", {31'd0, io_async_safe_ridx_valid}, 32'd1);
    transfer_exact("srcrst restart", 15'h7123, 2);

    // Local reset with an entry pending.
    send(15'h0F0F);
    repeat (5) tick();
    chk("lrst pending_valid", {31'd0, io_deq_valid}, 32'd1);
    reset = 1'b1;
    #1;
    chk("lrst deq_valid", {31'd0, io_deq_valid}, 32'd0);
    chk("lrst ridx", {31'd0, io_async_ridx}, 32'd0);
    chk("lrst ridx_valid", {31'd0, io_async_safe_ridx_valid}, 32'd0);
    chk("lrst sink_reset_n", {31'd0, io_async_safe_sink_reset_n}, 32'd0);
    io_async_widx = 1'b0;
    exp_ridx = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    bring_up("lrst bringup");
    transfer_exact("lrst restart", 15'h4001, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
